// File: rtl/hsst_rx_rst_pkg.sv
// -----------------------------------------------------------------------------
// hsst_rx_rst_pkg
// Shared types for the HSST RX lane reset sequencer.
//   rx_state_e      : state codes, also visible on rx_st
//   rx_out_t        : registered lane reset / watchdog controls
//   decode_outputs  : Moore decode of a state into rx_out_t
//   RETRY_W         : width of the restart counter
// -----------------------------------------------------------------------------
package hsst_rx_rst_pkg;

   localparam int RETRY_W = 8;

   typedef enum logic [2:0] {
      WAIT_PLL = 3'd0,
      PMA_RST  = 3'd1,
      WAIT_CDR = 3'd2,
      PCS_RST  = 3'd3,
      DONE     = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic pma_rx_rst;
      logic pcs_rx_rst;
      logic rx_done;
      logic wtchdg_clr;
      logic wtchdg_in;
   } rx_out_t;

   // WAIT_PLL values double as the reset values of the output registers.
   localparam rx_out_t RST_OUT = '{pma_rx_rst: 1'b1, pcs_rx_rst: 1'b1,
                                   rx_done: 1'b0, wtchdg_clr: 1'b1,
                                   wtchdg_in: 1'b0};

   function automatic rx_out_t decode_outputs(input rx_state_e st);
      rx_out_t o;
      o = RST_OUT;
      case (st)
         PMA_RST: o.wtchdg_clr = 1'b0;
         WAIT_CDR,
         PCS_RST: begin
            o.pma_rx_rst = 1'b0;
            o.wtchdg_clr = 1'b0;
         end
         DONE: o = '{pma_rx_rst: 1'b0, pcs_rx_rst: 1'b0, rx_done: 1'b1,
                     wtchdg_clr: 1'b0, wtchdg_in: 1'b1};
         default: o = RST_OUT;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/hsst_rx_lane_rst_fsm_if.sv
// -----------------------------------------------------------------------------
// hsst_rx_lane_rst_fsm_if
// Lane-side signals of the RX reset sequencer.
//   master : the sequencer (consumes lock/timeout, drives resets and status)
//   slave  : the lane/watchdog side
//   pll_lock, cdr_lock : asynchronous lock indications
//   wtchdg_rst_n_i     : watchdog timeout, active-low, synchronous to clk
//   pma_rx_rst, pcs_rx_rst, rx_done, wtchdg_clr_o, wtchdg_in_o, rx_st, retry_cnt
// -----------------------------------------------------------------------------
interface hsst_rx_lane_rst_fsm_if;
   import hsst_rx_rst_pkg::*;

   logic               pll_lock;
   logic               cdr_lock;
   logic               wtchdg_rst_n_i;
   logic               pma_rx_rst;
   logic               pcs_rx_rst;
   logic               rx_done;
   logic               wtchdg_clr_o;
   logic               wtchdg_in_o;
   logic [2:0]         rx_st;
   logic [RETRY_W-1:0] retry_cnt;

   modport master (
      input  pll_lock, cdr_lock, wtchdg_rst_n_i,
      output pma_rx_rst, pcs_rx_rst, rx_done, wtchdg_clr_o, wtchdg_in_o,
             rx_st, retry_cnt
   );

   modport slave (
      output pll_lock, cdr_lock, wtchdg_rst_n_i,
      input  pma_rx_rst, pcs_rx_rst, rx_done, wtchdg_clr_o, wtchdg_in_o,
             rx_st, retry_cnt
   );

endinterface

// File: rtl/hsst_rst_sync.sv
// -----------------------------------------------------------------------------
// hsst_rst_sync
// Generic 2-flop synchronizer, async active-low reset to 0.
//   clk, rst_n : clock / reset
//   d          : asynchronous input
//   q          : d re-timed to clk, two edges later
// -----------------------------------------------------------------------------
module hsst_rst_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], d};
   end

   assign q = sync_q[1];

endmodule

// File: rtl/hsst_rx_lane_rst_fsm.sv
// -----------------------------------------------------------------------------
// hsst_rx_lane_rst_fsm
// Per-lane HSST RX reset sequencer: PLL lock -> PMA reset pulse -> stable CDR
// lock -> PCS reset pulse -> done. Restarts on watchdog timeout, PLL or CDR loss.
//   clk, rst_n : lane reference clock, async active-low reset
//   lane       : hsst_rx_lane_rst_fsm_if.master (locks, timeout, resets, status)
// -----------------------------------------------------------------------------
module hsst_rx_lane_rst_fsm
   import hsst_rx_rst_pkg::*;
#(
   parameter int PMA_RST_CYC     = 32,
   parameter int PCS_RST_CYC     = 16,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int CNT_WIDTH       = 11
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hsst_rx_lane_rst_fsm_if.master lane
);

   localparam logic [CNT_WIDTH-1:0] PMA_LAST  = CNT_WIDTH'(PMA_RST_CYC - 1);
   localparam logic [CNT_WIDTH-1:0] PCS_LAST  = CNT_WIDTH'(PCS_RST_CYC - 1);
   localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYC - 1);

   logic pll_lock_s;
   logic cdr_lock_s;

   hsst_rst_sync u_pll_sync (.clk(clk), .rst_n(rst_n), .d(lane.pll_lock), .q(pll_lock_s));
   hsst_rst_sync u_cdr_sync (.clk(clk), .rst_n(rst_n), .d(lane.cdr_lock), .q(cdr_lock_s));

   rx_state_e            state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   rx_out_t              out_q, out_d;
   logic                 pll_loss;
   logic                 wd_restart;

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      cnt_d      = '0;
      pll_loss   = (state_q != WAIT_PLL) && !pll_lock_s;
      // Timeout is ignored in WAIT_PLL (watchdog held cleared) and in DONE
      // (kick holds it idle); PLL loss outranks it.
      wd_restart = !pll_loss && !lane.wtchdg_rst_n_i &&
                   (state_q inside {PMA_RST, WAIT_CDR, PCS_RST});

      if (pll_loss) begin
         state_d = WAIT_PLL;
      end else if (wd_restart) begin
         state_d = PMA_RST;
         if (retry_q != '1) retry_d = retry_q + 1'b1;
      end else begin
         case (state_q)
            WAIT_PLL: if (pll_lock_s) state_d = PMA_RST;
            PMA_RST:  if (cnt_q == PMA_LAST) state_d = WAIT_CDR;
            WAIT_CDR: if (cdr_lock_s && cnt_q == LOCK_LAST) state_d = PCS_RST;
            PCS_RST: begin
               if (!cdr_lock_s)            state_d = WAIT_CDR;
               else if (cnt_q == PCS_LAST) state_d = DONE;
            end
            DONE:     if (!cdr_lock_s) state_d = WAIT_CDR;
            default:  state_d = WAIT_PLL;
         endcase
      end

      // Counter restarts on any state change and on a watchdog re-entry of
      // PMA_RST; in WAIT_CDR it only accumulates consecutive lock cycles.
      if (!wd_restart && state_d == state_q) begin
         case (state_q)
            PMA_RST,
            PCS_RST:  cnt_d = cnt_q + 1'b1;
            WAIT_CDR: cnt_d = cdr_lock_s ? cnt_q + 1'b1 : '0;
            default:  cnt_d = '0;
         endcase
      end

      // Outputs decode the next state so they switch on the same edge as rx_st.
      out_d = decode_outputs(state_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT_PLL;
         cnt_q   <= '0;
         retry_q <= '0;
         out_q   <= RST_OUT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         out_q   <= out_d;
      end
   end

   assign lane.pma_rx_rst   = out_q.pma_rx_rst;
   assign lane.pcs_rx_rst   = out_q.pcs_rx_rst;
   assign lane.rx_done      = out_q.rx_done;
   assign lane.wtchdg_clr_o = out_q.wtchdg_clr;
   assign lane.wtchdg_in_o  = out_q.wtchdg_in;
   assign lane.rx_st        = state_q;
   assign lane.retry_cnt    = retry_q;

endmodule

// File: tb/tb_hsst_rx_lane_rst_fsm.sv
// -----------------------------------------------------------------------------
// tb_hsst_rx_lane_rst_fsm
// Self-checking bench for hsst_rx_lane_rst_fsm with default parameters.
// Inputs are driven 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_hsst_rx_lane_rst_fsm;

   logic clk = 1'b0;
   logic rst_n;

   hsst_rx_lane_rst_fsm_if lane ();

   hsst_rx_lane_rst_fsm dut (
      .clk  (clk),
      .rst_n(rst_n),
      .lane (lane)
   );

   always #5 clk = ~clk;

   // Output groups {pma, pcs, done, clr, kick} per state.
   localparam logic [4:0] O_WPLL = 5'b11010;
   localparam logic [4:0] O_PMA  = 5'b11000;
   localparam logic [4:0] O_CDR  = 5'b01000;
   localparam logic [4:0] O_PCS  = 5'b01000;
   localparam logic [4:0] O_DONE = 5'b00101;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic       pll;
      logic       cdr;
      logic       wd;
      int         cyc;
      logic [2:0] st;
      logic [4:0] outs;
      logic [7:0] retry;
   } vec_t;

   vec_t vecs[10];

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [2:0] st,
                        input logic [4:0] outs, input logic [7:0] retry);
      logic [2:0] a_st;
      logic [4:0] a_outs;
      logic [7:0] a_retry;
      a_st    = lane.rx_st;
      a_outs  = {lane.pma_rx_rst, lane.pcs_rx_rst, lane.rx_done,
                 lane.wtchdg_clr_o, lane.wtchdg_in_o};
      a_retry = lane.retry_cnt;
      checks++;
      if ({a_st, a_outs, a_retry} !== {st, outs, retry}) begin
         errors++;
         $display("FAIL %s: got st=%0d outs=%b retry=%0d, want st=%0d outs=%b retry=%0d",
                  name, a_st, a_outs, a_retry, st, outs, retry);
      end
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         lane.pll_lock       = vecs[i].pll;
         lane.cdr_lock       = vecs[i].cdr;
         lane.wtchdg_rst_n_i = vecs[i].wd;
         tick(vecs[i].cyc);
         check(vecs[i].name, vecs[i].st, vecs[i].outs, vecs[i].retry);
      end
   endtask

   initial begin
      // Nominal path: pll_lock driven after edge N gives PMA_RST at N+3,
      // WAIT_CDR 32 edges later, PCS_RST 1024 later, DONE 16 later.
      vecs[0] = '{"idle_no_pll",   1'b0, 1'b1, 1'b1, 5,    3'd0, O_WPLL, 8'd0};
      vecs[1] = '{"pll_in_sync",   1'b1, 1'b1, 1'b1, 2,    3'd0, O_WPLL, 8'd0};
      vecs[2] = '{"enter_pma",     1'b1, 1'b1, 1'b1, 1,    3'd1, O_PMA,  8'd0};
      vecs[3] = '{"pma_last_cyc",  1'b1, 1'b1, 1'b1, 31,   3'd1, O_PMA,  8'd0};
      vecs[4] = '{"enter_wcdr",    1'b1, 1'b1, 1'b1, 1,    3'd2, O_CDR,  8'd0};
      vecs[5] = '{"wcdr_last_cyc", 1'b1, 1'b1, 1'b1, 1023, 3'd2, O_CDR,  8'd0};
      vecs[6] = '{"enter_pcs",     1'b1, 1'b1, 1'b1, 1,    3'd3, O_PCS,  8'd0};
      vecs[7] = '{"pcs_last_cyc",  1'b1, 1'b1, 1'b1, 15,   3'd3, O_PCS,  8'd0};
      vecs[8] = '{"enter_done",    1'b1, 1'b1, 1'b1, 1,    3'd4, O_DONE, 8'd0};
      vecs[9] = '{"done_hold",     1'b1, 1'b1, 1'b1, 20,   3'd4, O_DONE, 8'd0};

      rst_n               = 1'b0;
      lane.pll_lock       = 1'b0;
      lane.cdr_lock       = 1'b1;
      lane.wtchdg_rst_n_i = 1'b1;
      tick(3);
      check("reset_values", 3'd0, O_WPLL, 8'd0);
      rst_n = 1'b1;

      run_vectors(0, 9);

      // PLL loss in DONE: visible after the third edge.
      lane.pll_lock = 1'b0;
      tick(2);
      check("pll_loss_sync", 3'd4, O_DONE, 8'd0);
      tick(1);
      check("pll_loss_done", 3'd0, O_WPLL, 8'd0);
      lane.pll_lock = 1'b1;
      tick(3);
      check("relock_pma", 3'd1, O_PMA, 8'd0);
      tick(32);
      check("relock_wcdr", 3'd2, O_CDR, 8'd0);

      // CDR glitch after 500 cycles of stable lock clears the counter.
      tick(500);
      check("glitch_pre", 3'd2, O_CDR, 8'd0);
      lane.cdr_lock = 1'b0;
      tick(1);
      lane.cdr_lock = 1'b1;
      tick(1025);
      check("glitch_not_yet", 3'd2, O_CDR, 8'd0);
      tick(1);
      check("glitch_pcs", 3'd3, O_PCS, 8'd0);
      tick(16);
      check("glitch_done", 3'd4, O_DONE, 8'd0);

      // CDR loss in DONE drops rx_done and re-asserts pcs_rx_rst.
      lane.cdr_lock = 1'b0;
      tick(3);
      check("cdr_loss_done", 3'd2, O_CDR, 8'd0);

      // Watchdog timeout held low for 3 cycles in WAIT_CDR.
      lane.wtchdg_rst_n_i = 1'b0;
      tick(1);
      check("wd_first", 3'd1, O_PMA, 8'd1);
      tick(2);
      check("wd_third", 3'd1, O_PMA, 8'd3);
      lane.wtchdg_rst_n_i = 1'b1;
      tick(31);
      check("wd_pma_hold", 3'd1, O_PMA, 8'd3);
      tick(1);
      check("wd_pma_fall", 3'd2, O_CDR, 8'd3);

      // PLL loss and timeout on the same edge in PCS_RST: PLL loss wins.
      lane.cdr_lock = 1'b1;
      tick(1026);
      check("prio_in_pcs", 3'd3, O_PCS, 8'd3);
      lane.pll_lock = 1'b0;
      tick(2);
      check("prio_pre", 3'd3, O_PCS, 8'd3);
      lane.wtchdg_rst_n_i = 1'b0;
      tick(1);
      check("prio_pll_wins", 3'd0, O_WPLL, 8'd3);
      lane.wtchdg_rst_n_i = 1'b1;

      // 300 consecutive timeouts in PMA_RST saturate retry_cnt at 255.
      lane.pll_lock = 1'b1;
      tick(3);
      check("sat_enter_pma", 3'd1, O_PMA, 8'd3);
      lane.wtchdg_rst_n_i = 1'b0;
      tick(251);
      check("sat_254", 3'd1, O_PMA, 8'd254);
      tick(1);
      check("sat_255", 3'd1, O_PMA, 8'd255);
      tick(48);
      check("sat_hold", 3'd1, O_PMA, 8'd255);
      lane.wtchdg_rst_n_i = 1'b1;
      tick(1056);
      check("sat_to_pcs", 3'd3, O_PCS, 8'd255);
      tick(5);

      // Mid-sequence reset in PCS_RST: immediate return to reset values.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 3'd0, O_WPLL, 8'd0);
      tick(2);
      check("reset_held", 3'd0, O_WPLL, 8'd0);
      rst_n = 1'b1;
      run_vectors(1, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
